// File: rtl/window_min_max.sv
// window_min_max: per-window unsigned max/min/first-max-index tracker with valid/ready handshakes
module window_min_max #(
  parameter int WIDTH      = 8,
  parameter int WINDOW_LEN = 16,
  parameter int IDX_W      = $clog2(WINDOW_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [IDX_W-1:0] out_max_idx,
  output logic             out_valid,
  input  logic             out_ready
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state;
  logic [IDX_W-1:0] count, run_idx, nxt_idx;
  logic [WIDTH-1:0] run_max, run_min, nxt_max, nxt_min;
  logic first, gt, lt, last, accept;
  assign in_ready = state == ACCUM;
  always_comb begin
    first   = count == '0;
    gt      = in_data > run_max;
    lt      = in_data < run_min;
    nxt_max = (first || gt) ? in_data : run_max;
    nxt_min = (first || lt) ? in_data : run_min;
    nxt_idx = first ? '0 : gt ? count : run_idx;
    last    = count == IDX_W'(WINDOW_LEN - 1);
    accept  = in_valid && in_ready && !clear;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      count       <= '0;
      run_max     <= '0;
      run_min     <= '0;
      run_idx     <= '0;
      out_max     <= '0;
      out_min     <= '0;
      out_max_idx <= '0;
      out_valid   <= 1'b0;
    end else if (clear) begin
      state     <= ACCUM;
      count     <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      run_max <= nxt_max;
      run_min <= nxt_min;
      run_idx <= nxt_idx;
      count   <= last ? '0 : count + 1'b1;
      if (last) begin
        out_max     <= nxt_max;
        out_min     <= nxt_min;
        out_max_idx <= nxt_idx;
        out_valid   <= 1'b1;
        state       <= HOLD;
      end
    end else if (state == HOLD && out_ready) begin
      out_valid <= 1'b0;
      state     <= ACCUM;
    end
  end
endmodule

// File: tb/tb_window_min_max.sv
// tb_window_min_max: scoreboard bench for window_min_max with WINDOW_LEN=4
module tb_window_min_max;
  localparam int L = 4;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, out_valid;
  logic [7:0] out_max, out_min;
  logic [1:0] out_max_idx;
  int vectors = 0, miscompares = 0;
  logic [17:0] sbq[$];
  logic [17:0] last_res = '0;

  window_min_max #(.WIDTH(8), .WINDOW_LEN(L)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_max(out_max), .out_min(out_min), .out_max_idx(out_max_idx),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Expected {max, min, index of first max} for a window packed MSB-first
  function automatic logic [17:0] model(input logic [31:0] w);
    logic [7:0] s, mx, mn;
    logic [1:0] ix;
    bit found;
    mx = 8'h00; mn = 8'hFF; ix = 2'd0; found = 0;
    for (int i = 0; i < 4; i++) begin
      s = w[31-8*i -: 8];
      if (s > mx) mx = s;
      if (s < mn) mn = s;
    end
    for (int i = 0; i < 4; i++) begin
      s = w[31-8*i -: 8];
      if (!found && s == mx) begin ix = 2'(i); found = 1; end
    end
    return {mx, mn, ix};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] w, input bit gaps);
    sbq.push_back(model(w));
    for (int i = 0; i < 4; i++) begin
      if (gaps && i[0]) begin
        in_valid = 1'b0; in_data = 8'hFF; tick;
        tick;
      end
      in_valid = 1'b1; in_data = w[31-8*i -: 8];
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL feed_ready[%0d]: in_ready=%b want 1", i, in_ready);
      end
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int stall, input string name);
    logic [17:0] e;
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick; n++; end
    vectors++;
    if (n != 0) begin
      miscompares++;
      $display("FAIL %s_latency: waited %0d cycles for out_valid, want 0", name, n);
    end
    e = sbq.pop_front();
    last_res = e;
    vectors++;
    if ({out_valid, in_ready, out_max, out_min, out_max_idx} !== {2'b10, e}) begin
      miscompares++;
      $display("FAIL %s_result: v/r/max/min/idx=%b%b %h %h %0d want 10 %h %h %0d",
               name, out_valid, in_ready, out_max, out_min, out_max_idx, e[17:10], e[9:2], e[1:0]);
    end
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1; in_data = 8'(k * 37 + 3);
      tick;
      vectors++;
      if ({out_valid, in_ready, out_max, out_min, out_max_idx} !== {2'b10, e}) begin
        miscompares++;
        $display("FAIL %s_hold[%0d]: v/r=%b%b max=%h min=%h idx=%0d want 10 %h %h %0d",
                 name, k, out_valid, in_ready, out_max, out_min, out_max_idx, e[17:10], e[9:2], e[1:0]);
      end
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hFE;
    tick;
    out_ready = 1'b0; in_valid = 1'b0;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL %s_consume: valid/ready=%b%b want 01", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    tick;
    vectors++;
    if ({out_valid, in_ready, out_max, out_min, out_max_idx} !== {2'b01, 18'h0}) begin
      miscompares++;
      $display("FAIL reset: v/r=%b%b max=%h min=%h idx=%0d want 01 00 00 0",
               out_valid, in_ready, out_max, out_min, out_max_idx);
    end
    #3 rst_n = 1'b1;
    tick;
  endtask

  task automatic test_ascending;
    feed(32'h10203040, 0);
    drain(0, "ascending");
  endtask

  task automatic test_ties;
    feed(32'h80058005, 0);
    drain(0, "ties");
  endtask

  task automatic test_backpressure;
    feed(32'hFF007F01, 0);
    drain(5, "backpressure");
  endtask

  task automatic test_clear;
    in_valid = 1'b1; in_data = 8'hAA; tick;
    in_data = 8'hBB; tick;
    clear = 1'b1; in_data = 8'hFF; tick;
    clear = 1'b0; in_valid = 1'b0;
    vectors++;
    if ({out_valid, in_ready, out_max, out_min, out_max_idx} !== {2'b01, last_res}) begin
      miscompares++;
      $display("FAIL clear_partial: v/r=%b%b max=%h min=%h idx=%0d want 01 %h %h %0d",
               out_valid, in_ready, out_max, out_min, out_max_idx, last_res[17:10], last_res[9:2], last_res[1:0]);
    end
    feed(32'h09030C07, 1);
    drain(2, "clear_window");
  endtask

  task automatic test_clear_hold;
    feed(32'h44112233, 0);
    last_res = sbq.pop_back();
    clear = 1'b1; tick;
    clear = 1'b0;
    vectors++;
    if ({out_valid, in_ready, out_max, out_min, out_max_idx} !== {2'b01, last_res}) begin
      miscompares++;
      $display("FAIL clear_hold: v/r=%b%b max=%h min=%h idx=%0d want 01 %h %h %0d",
               out_valid, in_ready, out_max, out_min, out_max_idx, last_res[17:10], last_res[9:2], last_res[1:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] wins [3];
    logic [17:0] e;
    wins[0] = 32'h01FF02FF; wins[1] = 32'h33221100; wins[2] = 32'h5A5A5A5A;
    out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      sbq.push_back(model(wins[w]));
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1; in_data = wins[w][31-8*i -: 8];
        tick;
      end
      e = sbq.pop_front();
      vectors++;
      if ({out_valid, in_ready, out_max, out_min, out_max_idx} !== {2'b10, e}) begin
        miscompares++;
        $display("FAIL b2b_result[%0d]: v/r=%b%b max=%h min=%h idx=%0d want 10 %h %h %0d",
                 w, out_valid, in_ready, out_max, out_min, out_max_idx, e[17:10], e[9:2], e[1:0]);
      end
      in_data = 8'hEE;
      tick;
      vectors++;
      if ({out_valid, in_ready} !== 2'b01) begin
        miscompares++;
        $display("FAIL b2b_period[%0d]: valid/ready=%b%b want 01", w, out_valid, in_ready);
      end
    end
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_async_reset;
    in_valid = 1'b1; in_data = 8'h99; tick;
    in_data = 8'h11; tick;
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, in_ready, out_max, out_min, out_max_idx} !== {2'b01, 18'h0}) begin
      miscompares++;
      $display("FAIL async_reset: v/r=%b%b max=%h min=%h idx=%0d want 01 00 00 0",
               out_valid, in_ready, out_max, out_min, out_max_idx);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    feed(32'h01020304, 0);
    drain(0, "after_reset");
  endtask

  initial begin
    test_reset;
    test_ascending;
    test_ties;
    test_backpressure;
    test_clear;
    test_clear_hold;
    test_back_to_back;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
